// File: rtl/operand_fetch_if.sv
// rtl/operand_fetch_if.sv - decode, register-file, forwarding and execute bundle for operand_fetch
// master drives decode/forwarding/regfile data; slave is the operand_fetch stage.
interface operand_fetch_if #(
   parameter int WIDTH  = 32,
   parameter int NUM    = 32,
   parameter int CTRL_W = 16
);
   localparam int AW = $clog2(NUM);

   logic              flush;

   logic              in_valid;
   logic              in_ready;
   logic [AW-1:0]     in_rs1;
   logic [AW-1:0]     in_rs2;
   logic              in_rs1_used;
   logic              in_rs2_used;
   logic [AW-1:0]     in_rd;
   logic [CTRL_W-1:0] in_ctrl;

   logic [AW-1:0]     gpr_addr_r1;
   logic [AW-1:0]     gpr_addr_r2;
   logic [WIDTH-1:0]  gpr_data_r1;
   logic [WIDTH-1:0]  gpr_data_r2;

   logic              ex_fwd_valid;
   logic [AW-1:0]     ex_fwd_rd;
   logic [WIDTH-1:0]  ex_fwd_data;
   logic              ex_pend_valid;
   logic [AW-1:0]     ex_pend_rd;
   logic              mem_fwd_valid;
   logic [AW-1:0]     mem_fwd_rd;
   logic [WIDTH-1:0]  mem_fwd_data;

   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  out_rs1_data;
   logic [WIDTH-1:0]  out_rs2_data;
   logic [AW-1:0]     out_rd;
   logic [CTRL_W-1:0] out_ctrl;
   logic [31:0]       stall_count;

   modport master (
      output flush, in_valid, in_rs1, in_rs2, in_rs1_used, in_rs2_used, in_rd, in_ctrl,
             gpr_data_r1, gpr_data_r2,
             ex_fwd_valid, ex_fwd_rd, ex_fwd_data, ex_pend_valid, ex_pend_rd,
             mem_fwd_valid, mem_fwd_rd, mem_fwd_data, out_ready,
      input  in_ready, gpr_addr_r1, gpr_addr_r2,
             out_valid, out_rs1_data, out_rs2_data, out_rd, out_ctrl, stall_count
   );

   modport slave (
      input  flush, in_valid, in_rs1, in_rs2, in_rs1_used, in_rs2_used, in_rd, in_ctrl,
             gpr_data_r1, gpr_data_r2,
             ex_fwd_valid, ex_fwd_rd, ex_fwd_data, ex_pend_valid, ex_pend_rd,
             mem_fwd_valid, mem_fwd_rd, mem_fwd_data, out_ready,
      output in_ready, gpr_addr_r1, gpr_addr_r2,
             out_valid, out_rs1_data, out_rs2_data, out_rd, out_ctrl, stall_count
   );
endinterface

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - decode-to-execute operand fetch stage with EX/MEM forwarding
// Resolves both sources, stalls on load-use, holds one instruction for execute.
module operand_fetch #(
   parameter int WIDTH  = 32,
   parameter int NUM    = 32,
   parameter int CTRL_W = 16
) (
   input logic          clock,
   input logic          reset,
   operand_fetch_if.slave bus
);
   localparam int AW = $clog2(NUM);

   logic              hazard;
   logic              ready;
   logic              accept;
   logic              rs1_pend_hit;
   logic              rs2_pend_hit;
   logic [WIDTH-1:0]  op1;
   logic [WIDTH-1:0]  op2;

   logic              out_valid_q;
   logic [WIDTH-1:0]  rs1_data_q;
   logic [WIDTH-1:0]  rs2_data_q;
   logic [AW-1:0]     rd_q;
   logic [CTRL_W-1:0] ctrl_q;
   logic [31:0]       stall_q;

   // x0 is hardwired zero and must never pick up a forwarded value; EX is younger than MEM.
   function automatic logic [WIDTH-1:0] resolve(
      input logic [AW-1:0]    rs,
      input logic [WIDTH-1:0] rf_data,
      input logic             ex_v,
      input logic [AW-1:0]    ex_rd,
      input logic [WIDTH-1:0] ex_d,
      input logic             mem_v,
      input logic [AW-1:0]    mem_rd,
      input logic [WIDTH-1:0] mem_d
   );
      logic [WIDTH-1:0] r;
      if (rs == '0)
         r = '0;
      else if (ex_v && ex_rd == rs)
         r = ex_d;
      else if (mem_v && mem_rd == rs)
         r = mem_d;
      else
         r = rf_data;
      return r;
   endfunction

   assign bus.gpr_addr_r1 = bus.in_rs1;
   assign bus.gpr_addr_r2 = bus.in_rs2;

   always_comb begin
      op1 = resolve(bus.in_rs1, bus.gpr_data_r1,
                    bus.ex_fwd_valid, bus.ex_fwd_rd, bus.ex_fwd_data,
                    bus.mem_fwd_valid, bus.mem_fwd_rd, bus.mem_fwd_data);
      op2 = resolve(bus.in_rs2, bus.gpr_data_r2,
                    bus.ex_fwd_valid, bus.ex_fwd_rd, bus.ex_fwd_data,
                    bus.mem_fwd_valid, bus.mem_fwd_rd, bus.mem_fwd_data);
   end

   always_comb begin
      rs1_pend_hit = bus.in_rs1_used && (bus.ex_pend_rd == bus.in_rs1);
      rs2_pend_hit = bus.in_rs2_used && (bus.ex_pend_rd == bus.in_rs2);
      hazard       = bus.in_valid && bus.ex_pend_valid && (bus.ex_pend_rd != '0) &&
                     (rs1_pend_hit || rs2_pend_hit);
   end

   assign ready  = !hazard && (!out_valid_q || bus.out_ready) && !bus.flush;
   assign accept = bus.in_valid && ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         rs1_data_q  <= '0;
         rs2_data_q  <= '0;
         rd_q        <= '0;
         ctrl_q      <= '0;
         stall_q     <= '0;
      end else begin
         if (hazard && stall_q != 32'hFFFF_FFFF)
            stall_q <= stall_q + 32'd1;

         // Operands are frozen at capture; a held entry is never re-forwarded.
         if (bus.flush) begin
            out_valid_q <= 1'b0;
         end else if (accept) begin
            out_valid_q <= 1'b1;
            rs1_data_q  <= op1;
            rs2_data_q  <= op2;
            rd_q        <= bus.in_rd;
            ctrl_q      <= bus.in_ctrl;
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.in_ready     = ready;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_rs1_data = rs1_data_q;
   assign bus.out_rs2_data = rs2_data_q;
   assign bus.out_rd       = rd_q;
   assign bus.out_ctrl     = ctrl_q;
   assign bus.stall_count  = stall_q;
endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - scoreboard bench for operand_fetch
// Stimulus pushes hand-computed expectations; a negedge monitor pops on each output transfer.
module tb_operand_fetch;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   operand_fetch_if #(.WIDTH(32), .NUM(32), .CTRL_W(16)) bus ();

   operand_fetch #(.WIDTH(32), .NUM(32), .CTRL_W(16)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [31:0] d1;
      logic [31:0] d2;
      logic [4:0]  rd;
      logic [15:0] ctrl;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [31:0] rf [32];
   int          n_checks = 0;
   int          n_fail   = 0;

   assign bus.gpr_data_r1 = rf[bus.gpr_addr_r1];
   assign bus.gpr_data_r2 = rf[bus.gpr_addr_r2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (!reset && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got rd=%0d ctrl=0x%04h expected no transfer",
                     bus.out_rd, bus.out_ctrl);
         end else begin
            mon_e = exp_q.pop_front();
            check("out_rs1_data", bus.out_rs1_data, mon_e.d1);
            check("out_rs2_data", bus.out_rs2_data, mon_e.d2);
            check("out_rd", {27'd0, bus.out_rd}, {27'd0, mon_e.rd});
            check("out_ctrl", {16'd0, bus.out_ctrl}, {16'd0, mon_e.ctrl});
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      bus.flush         = 1'b0;
      bus.in_valid      = 1'b0;
      bus.in_rs1        = '0;
      bus.in_rs2        = '0;
      bus.in_rs1_used   = 1'b0;
      bus.in_rs2_used   = 1'b0;
      bus.in_rd         = '0;
      bus.in_ctrl       = '0;
      bus.ex_fwd_valid  = 1'b0;
      bus.ex_fwd_rd     = '0;
      bus.ex_fwd_data   = '0;
      bus.ex_pend_valid = 1'b0;
      bus.ex_pend_rd    = '0;
      bus.mem_fwd_valid = 1'b0;
      bus.mem_fwd_rd    = '0;
      bus.mem_fwd_data  = '0;
   endtask

   task automatic drive_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                           input logic u2, input logic [4:0] rd, input logic [15:0] ctrl);
      bus.in_valid    = 1'b1;
      bus.in_rs1      = rs1;
      bus.in_rs2      = rs2;
      bus.in_rs1_used = u1;
      bus.in_rs2_used = u2;
      bus.in_rd       = rd;
      bus.in_ctrl     = ctrl;
   endtask

   task automatic set_ex(input logic v, input logic [4:0] rd, input logic [31:0] d);
      bus.ex_fwd_valid = v;
      bus.ex_fwd_rd    = rd;
      bus.ex_fwd_data  = d;
   endtask

   task automatic set_mem(input logic v, input logic [4:0] rd, input logic [31:0] d);
      bus.mem_fwd_valid = v;
      bus.mem_fwd_rd    = rd;
      bus.mem_fwd_data  = d;
   endtask

   // Presents one instruction until accepted; 'now' requires acceptance in the first cycle.
   task automatic send(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic [4:0] rd, input logic [15:0] ctrl,
                       input logic [31:0] e1, input logic [31:0] e2, input bit now);
      bit done = 1'b0;
      drive_in(rs1, rs2, u1, u2, rd, ctrl);
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge clock);
         if (now && k == 0)
            check("accept_first_cycle", {31'd0, bus.in_ready}, 32'd1);
         if (bus.in_ready) begin
            exp_q.push_back('{d1: e1, d2: e2, rd: rd, ctrl: ctrl});
            done = 1'b1;
         end
         step();
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: got no accept for rd=%0d expected accept", rd);
      end
      bus.in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected end of test");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 32; i++)
         rf[i] = 32'hA000_0000 + i;
      rf[5] = 32'h0000_0011;
      rf[6] = 32'h0000_0066;
      idle();
      bus.out_ready = 1'b1;
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;

      @(negedge clock);
      check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("reset_stall_count", bus.stall_count, 32'd0);
      check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
      step();

      // forwarding priority on both sources
      set_ex(1, 5, 32'h33); set_mem(1, 5, 32'h22);
      send(5, 6, 1, 1, 5'd1, 16'h0001, 32'h33, 32'h66, 1);
      set_ex(0, 5, 32'h33);
      send(5, 6, 1, 1, 5'd2, 16'h0002, 32'h22, 32'h66, 1);
      set_mem(0, 5, 32'h22);
      send(5, 6, 1, 1, 5'd3, 16'h0003, 32'h11, 32'h66, 1);
      set_ex(1, 0, 32'h33); set_mem(1, 0, 32'h44);
      send(0, 6, 1, 1, 5'd4, 16'h0004, 32'h0, 32'h66, 1);
      set_ex(1, 6, 32'h77); set_mem(1, 5, 32'h55);
      send(5, 6, 1, 1, 5'd5, 16'h0005, 32'h55, 32'h77, 1);
      set_ex(1, 6, 32'h88); set_mem(1, 6, 32'h99);
      send(6, 6, 1, 1, 5'd6, 16'h0006, 32'h88, 32'h88, 1);
      idle();
      step(); step();
      check("fwd_drained", exp_q.size(), 32'd0);

      // load-use: two hazard cycles, load data arrives via MEM
      send(1, 2, 1, 1, 5'd8, 16'h0010, 32'hA000_0001, 32'hA000_0002, 1);
      bus.ex_pend_valid = 1'b1; bus.ex_pend_rd = 5'd7;
      drive_in(3, 7, 1, 1, 5'd10, 16'h0011);
      @(negedge clock);
      check("lu_ready_c0", {31'd0, bus.in_ready}, 32'd0);
      check("lu_prev_out", {31'd0, bus.out_valid}, 32'd1);
      step();
      @(negedge clock);
      check("lu_ready_c1", {31'd0, bus.in_ready}, 32'd0);
      check("lu_bubble", {31'd0, bus.out_valid}, 32'd0);
      step();
      bus.ex_pend_valid = 1'b0;
      set_mem(1, 7, 32'h7777);
      send(3, 7, 1, 1, 5'd10, 16'h0011, 32'hA000_0003, 32'h7777, 1);
      set_mem(0, 0, 32'h0);
      @(negedge clock);
      check("lu_stall_count", bus.stall_count, 32'd2);
      step();

      // pending load against unused source or x0 never stalls
      bus.ex_pend_valid = 1'b1; bus.ex_pend_rd = 5'd7;
      send(3, 7, 1, 0, 5'd11, 16'h0012, 32'hA000_0003, 32'hA000_0007, 1);
      bus.ex_pend_rd = 5'd0;
      send(0, 0, 1, 1, 5'd12, 16'h0013, 32'h0, 32'h0, 1);
      bus.ex_pend_valid = 1'b0;
      @(negedge clock);
      check("nostall_count", bus.stall_count, 32'd2);
      step(); step();

      // backpressure: held entry is stable and not re-forwarded
      bus.out_ready = 1'b0;
      send(1, 2, 1, 1, 5'd13, 16'h0020, 32'hA000_0001, 32'hA000_0002, 1);
      set_ex(1, 1, 32'hDEAD);
      drive_in(3, 4, 1, 1, 5'd14, 16'h0021);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
         check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
         check("bp_rs1_held", bus.out_rs1_data, 32'hA000_0001);
         check("bp_rs2_held", bus.out_rs2_data, 32'hA000_0002);
         check("bp_rd_held", {27'd0, bus.out_rd}, 32'd13);
         check("bp_ctrl_held", {16'd0, bus.out_ctrl}, 32'h0020);
         step();
      end
      bus.out_ready = 1'b1;
      send(3, 4, 1, 1, 5'd14, 16'h0021, 32'hA000_0003, 32'hA000_0004, 1);
      set_ex(0, 0, 32'h0);
      send(8, 9, 1, 1, 5'd15, 16'h0022, 32'hA000_0008, 32'hA000_0009, 1);
      @(negedge clock);
      check("b2b_no_bubble", {31'd0, bus.out_valid}, 32'd1);
      step();
      step();

      // flush kills the held entry and blocks capture
      bus.out_ready = 1'b0;
      send(1, 1, 1, 1, 5'd16, 16'h0030, 32'hA000_0001, 32'hA000_0001, 1);
      drive_in(2, 2, 1, 1, 5'd17, 16'h0031);
      bus.flush = 1'b1;
      @(negedge clock);
      check("flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
      step();
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      exp_q.delete();
      @(negedge clock);
      check("flush_kill", {31'd0, bus.out_valid}, 32'd0);
      step();
      bus.out_ready = 1'b1;
      drive_in(3, 3, 1, 1, 5'd18, 16'h0032);
      bus.flush = 1'b1;
      @(negedge clock);
      check("flush_blocks_ready", {31'd0, bus.in_ready}, 32'd0);
      step();
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clock);
      check("flush_no_capture", {31'd0, bus.out_valid}, 32'd0);
      step();

      // reset mid-transfer with a stalled instruction waiting
      bus.out_ready = 1'b0;
      send(1, 2, 1, 1, 5'd19, 16'h0040, 32'hA000_0001, 32'hA000_0002, 1);
      bus.ex_pend_valid = 1'b1; bus.ex_pend_rd = 5'd2;
      drive_in(4, 2, 1, 1, 5'd20, 16'h0041);
      step();
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      idle();
      exp_q.delete();
      @(negedge clock);
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_stall_count", bus.stall_count, 32'd0);
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      bus.out_ready = 1'b1;
      step();

      // saturation from a preloaded count
      @(negedge clock);
      force dut.stall_q = 32'hFFFF_FFFD;
      #1;
      release dut.stall_q;
      check("sat_preload", bus.stall_count, 32'hFFFF_FFFD);
      step();
      bus.ex_pend_valid = 1'b1; bus.ex_pend_rd = 5'd9;
      drive_in(9, 0, 1, 0, 5'd21, 16'h0050);
      for (int k = 1; k <= 5; k++) begin
         longint e;
         e = 64'h0000_0000_FFFF_FFFD + longint'(k);
         if (e > 64'h0000_0000_FFFF_FFFF)
            e = 64'h0000_0000_FFFF_FFFF;
         step();
         @(negedge clock);
         check("sat_count", bus.stall_count, e[31:0]);
         check("sat_in_ready", {31'd0, bus.in_ready}, 32'd0);
      end
      idle();
      step(); step();
      check("final_queue_empty", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
